// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
//
// Purpose : rx FSM state enum, frame constants and standard CLK_DIV defaults
//           (50 MHz system clock, 16x oversampling).
// Ports   : none (package).
// Macro   : UART_RX_PARITY_EN adds the PARITY state to the enum.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    // System clocks per oversample tick at 50 MHz.
    localparam int CLK_DIV_9600   = 326;
    localparam int CLK_DIV_19200  = 163;
    localparam int CLK_DIV_38400  = 81;
    localparam int CLK_DIV_57600  = 54;
    localparam int CLK_DIV_115200 = 27;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_tick_gen.sv
// rtl/uart_tick_gen.sv - oversample clock-enable generator
//
// Purpose : counts 0..CLK_DIV-1 while en is high; tick is high for the one
//           clock at CLK_DIV-1. clr restarts the count from 0.
// Ports   : clk  - system clock
//           rst  - asynchronous active-high reset
//           clr  - synchronous counter clear
//           en   - count enable
//           tick - oversample clock-enable
module uart_tick_gen #(
    parameter int CLK_DIV   = 27,
    parameter int DIV_WIDTH = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(CLK_DIV - 1);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling 8N1 UART receiver with valid/ack holding register
//
// Purpose : synchronizes rx, detects the start edge, samples each bit at its
//           centre and delivers good bytes through data_out/data_valid.
// Ports   : clk, rst (async active-high)
//           rx         - serial line, idle high, asynchronous to clk
//           data_out   - last good byte (LSB received first)
//           data_valid - high from delivery until data_ack
//           data_ack   - clears data_valid on the next rising edge
//           frame_err  - 1-cycle pulse, stop bit sampled low
//           overrun    - 1-cycle pulse, good byte delivered over an unacked one
//           parity_err - 1-cycle pulse, even-parity mismatch (0 without parity)
// Macro   : UART_RX_PARITY_EN enables one even-parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_115200,
    parameter int DIV_WIDTH = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam logic [3:0] MID_SAMPLE  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);

    rx_state_e  state_q;
    logic       sync1_q;
    logic       rxs_q;
    logic       rxs_prev_q;
    logic [3:0] scnt_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q;
    logic       brk_q;
    logic [7:0] data_out_q;
    logic       data_valid_q;
    logic       frame_err_q;
    logic       overrun_q;
`ifdef UART_RX_PARITY_EN
    logic       par_err_q;
    logic       parity_err_q;
`endif

    logic tick;
    logic start_edge;

    assign start_edge = (state_q == ST_IDLE) && rxs_prev_q && !rxs_q;

    uart_tick_gen #(
        .CLK_DIV   (CLK_DIV),
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_edge),
        .en   (state_q != ST_IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            scnt_q       <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            brk_q        <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= rx;
            rxs_q       <= sync1_q;
            rxs_prev_q  <= rxs_q;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // A delivery later in this block overrides the ack clear.
            if (data_ack) begin
                data_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        scnt_q    <= '0;
                        bit_idx_q <= '0;
                        brk_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        par_err_q <= 1'b0;
`endif
                        state_q   <= ST_START;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        if (scnt_q == MID_SAMPLE) begin
                            if (!rxs_q) begin
                                // Re-centre: from here every 16th tick lands mid-bit.
                                scnt_q  <= '0;
                                state_q <= ST_DATA;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            scnt_q <= scnt_q + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        scnt_q <= scnt_q + 1'b1;
                        if (scnt_q == LAST_SAMPLE) begin
                            shift_q   <= {rxs_q, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 1'b1;
                            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= ST_PARITY;
`else
                                state_q <= ST_STOP;
`endif
                            end
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        scnt_q <= scnt_q + 1'b1;
                        if (scnt_q == LAST_SAMPLE) begin
                            // Even parity: the parity bit must equal the XOR of the data.
                            par_err_q <= rxs_q ^ (^shift_q);
                            state_q   <= ST_STOP;
                        end
                    end
                end
`endif

                ST_STOP: begin
                    if (brk_q) begin
                        // Line held low after a bad stop bit: wait for idle so a
                        // break does not look like a new start edge.
                        if (rxs_q) begin
                            state_q <= ST_IDLE;
                        end
                    end else if (tick) begin
                        scnt_q <= scnt_q + 1'b1;
                        if (scnt_q == LAST_SAMPLE) begin
                            if (!rxs_q) begin
                                frame_err_q <= 1'b1;
                                brk_q       <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                                if (par_err_q) begin
                                    parity_err_q <= 1'b1;
                                end else begin
                                    data_out_q   <= shift_q;
                                    data_valid_q <= 1'b1;
                                    overrun_q    <= data_valid_q && !data_ack;
                                end
`else
                                data_out_q   <= shift_q;
                                data_valid_q <= 1'b1;
                                overrun_q    <= data_valid_q && !data_ack;
`endif
                            end
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx at CLK_DIV=4
module tb_uart_rx;

    localparam int CDIV = 4;
    localparam int BIT  = 16 * CDIV;

    localparam int EV_DELIVER = 0;
    localparam int EV_OVERRUN = 1;
    localparam int EV_FRAME   = 2;
    localparam int EV_PARITY  = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       valid;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   t_valid  = -1;
    exp_t exp_q[$];

    uart_rx #(.CLK_DIV(CDIV), .DIV_WIDTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] d, input logic v);
        exp_t e;
        e.kind  = kind;
        e.data  = d;
        e.valid = v;
        exp_q.push_back(e);
    endtask

    task automatic handle_event(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual=%0d required=none", kind);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_data_out", data_out, e.data);
            chk("event_data_valid", data_valid, e.valid);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every event.
    logic dv_p = 1'b0, ov_p = 1'b0, fe_p = 1'b0, pe_p = 1'b0;
    int   ov_w = 0, fe_w = 0, pe_w = 0;
    always @(negedge clk) begin
        if (data_valid && !dv_p) begin
            t_valid = cyc;
            handle_event(EV_DELIVER);
        end
        if (overrun && !ov_p)    handle_event(EV_OVERRUN);
        if (frame_err && !fe_p)  handle_event(EV_FRAME);
        if (parity_err && !pe_p) handle_event(EV_PARITY);
        if (overrun) ov_w++;
        else if (ov_w != 0) begin chk("overrun_width", ov_w, 1); ov_w = 0; end
        if (frame_err) fe_w++;
        else if (fe_w != 0) begin chk("frame_err_width", fe_w, 1); fe_w = 0; end
        if (parity_err) pe_w++;
        else if (pe_w != 0) begin chk("parity_err_width", pe_w, 1); pe_w = 0; end
        dv_p = data_valid;
        ov_p = overrun;
        fe_p = frame_err;
        pe_p = parity_err;
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic has_par, input logic par_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (has_par) drive_bit(par_bit);
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        chk("ack_clears_valid", data_valid, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data_out"}, data_out, 8'h00);
        chk({tag, "_data_valid"}, data_valid, 1'b0);
        chk({tag, "_frame_err"}, frame_err, 1'b0);
        chk({tag, "_overrun"}, overrun, 1'b0);
        chk({tag, "_parity_err"}, parity_err, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_start;
        int lat;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 0x55, no ack: latency 2+152*4 = 610 +-1 clocks, valid stays high.
        push(EV_DELIVER, 8'h55, 1'b1);
        t_start = cyc;
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        lat = t_valid - t_start;
        checks++;
        if (lat < 609 || lat > 611) begin
            failures++;
            $display("FAIL latency actual=%0d required=609..611", lat);
        end
        repeat (100) @(negedge clk);
        chk("valid_held", data_valid, 1'b1);
        chk("data_55", data_out, 8'h55);
        ack_pulse();

        // 0xA3 then 0x0F back-to-back without ack: second one overruns.
        push(EV_DELIVER, 8'hA3, 1'b1);
        push(EV_OVERRUN, 8'h0F, 1'b1);
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        chk("overrun_valid_kept", data_valid, 1'b1);
        chk("overrun_data", data_out, 8'h0F);
        ack_pulse();

        // Half-bit glitch: no output at all.
        rx = 1'b0;
        repeat (BIT / 2) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_valid", data_valid, 1'b0);
        chk("glitch_data", data_out, 8'h0F);

        // 0x3C with low stop bit plus 3 bit periods of break.
        push(EV_FRAME, 8'h0F, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("frame_data_kept", data_out, 8'h0F);
        chk("frame_no_valid", data_valid, 1'b0);

        // Reset during data bit 4, then 0x81.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i));
        rx = 1'b0;
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midframe_rst");
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (BIT) @(negedge clk);
        push(EV_DELIVER, 8'h81, 1'b1);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        chk("after_rst_data", data_out, 8'h81);

`ifdef UART_RX_PARITY_EN
        ack_pulse();
        push(EV_PARITY, 8'h81, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        push(EV_DELIVER, 8'h07, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk("parity_good_data", data_out, 8'h07);
`endif

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
